walker_arbiter: RTL and testbench

- Shares one LED request-walker (1 Hz strobed, busy-flagged) between NREQ independent requesters.
- Latches request pulses into a pending set and grants round-robin.
- Drives the walker request line until the walker accepts, then waits for the walk to finish.
- Reports accept/done per requester; sits between user-facing buttons/CPU strobes and the walker.

---
 rtl/walker_arbiter.sv | 162 ++++++++++++++++
 tb/tb_walker_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/walker_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : walker_arbiter
// Purpose  : Round-robin sharing of one strobed LED walker between NREQ
//            requesters. Optional ISSUE timeout: WALKER_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module walker_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 36_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req,
    output logic [NREQ-1:0]         o_ack,
    output logic [NREQ-1:0]         o_done,
    output logic                    o_walk_req,
    input  logic                    i_walk_busy,
    output logic [$clog2(NREQ)-1:0] o_grant_id,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int         c_W     = $clog2(NREQ);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WALK  = 2'd2;

    logic [1:0]      r_state_q,    w_state_d;
    logic [NREQ-1:0] r_pending_q,  w_pending_d;
    logic [c_W-1:0]  r_rr_q,       w_rr_d;
    logic [c_W-1:0]  r_grant_q,    w_grant_d;
    logic            r_walk_req_q, w_walk_req_d;
    logic [NREQ-1:0] r_ack_q,      w_ack_d;
    logic [NREQ-1:0] r_done_q,     w_done_d;
    logic            r_busy_q,     w_busy_d;
    logic            r_err_q,      w_err_d;
`ifdef WALKER_ARB_TIMEOUT_EN
    logic [31:0]     r_cnt_q,      w_cnt_d;
`endif

    logic           w_found;
    logic [c_W-1:0] w_win;
    logic [c_W:0]   w_idx;

    // Search pending from rr pointer upward, wrapping past NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_rr_q} + (c_W+1)'(i);
            if (w_idx >= (c_W+1)'(NREQ)) begin
                w_idx = w_idx - (c_W+1)'(NREQ);
            end
            if (!w_found && r_pending_q[w_idx[c_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_pending_d  = r_pending_q;
        w_rr_d       = r_rr_q;
        w_grant_d    = r_grant_q;
        w_walk_req_d = r_walk_req_q;
        w_ack_d      = '0;
        w_done_d     = '0;
        w_err_d      = 1'b0;
`ifdef WALKER_ARB_TIMEOUT_EN
        w_cnt_d      = r_cnt_q;
`endif
        case (r_state_q)
            c_IDLE: begin
                if (w_found && !i_walk_busy) begin
                    w_state_d          = c_ISSUE;
                    w_grant_d          = w_win;
                    w_walk_req_d       = 1'b1;
                    w_pending_d[w_win] = 1'b0;
                    w_rr_d             = (w_win == c_W'(NREQ-1)) ? '0 : w_win + 1'b1;
`ifdef WALKER_ARB_TIMEOUT_EN
                    w_cnt_d            = '0;
`endif
                end
            end
            c_ISSUE: begin
                if (i_walk_busy) begin
                    w_walk_req_d       = 1'b0;
                    w_ack_d[r_grant_q] = 1'b1;
                    w_state_d          = c_WALK;
                end
`ifdef WALKER_ARB_TIMEOUT_EN
                else if (r_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    w_walk_req_d = 1'b0;
                    w_err_d      = 1'b1;
                    w_state_d    = c_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q + 32'd1;
                end
`endif
            end
            c_WALK: begin
                if (!i_walk_busy) begin
                    w_done_d[r_grant_q] = 1'b1;
                    w_state_d           = c_IDLE;
                end
            end
            default: begin
                w_state_d    = c_IDLE;
                w_walk_req_d = 1'b0;
            end
        endcase
        // New requests are OR-ed in last so a same-cycle re-request survives its own grant.
        w_pending_d = w_pending_d | i_req;
        w_busy_d    = (w_state_d != c_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q    <= c_IDLE;
            r_pending_q  <= '0;
            r_rr_q       <= '0;
            r_grant_q    <= '0;
            r_walk_req_q <= 1'b0;
            r_ack_q      <= '0;
            r_done_q     <= '0;
            r_busy_q     <= 1'b0;
            r_err_q      <= 1'b0;
`ifdef WALKER_ARB_TIMEOUT_EN
            r_cnt_q      <= '0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_pending_q  <= w_pending_d;
            r_rr_q       <= w_rr_d;
            r_grant_q    <= w_grant_d;
            r_walk_req_q <= w_walk_req_d;
            r_ack_q      <= w_ack_d;
            r_done_q     <= w_done_d;
            r_busy_q     <= w_busy_d;
            r_err_q      <= w_err_d;
`ifdef WALKER_ARB_TIMEOUT_EN
            r_cnt_q      <= w_cnt_d;
`endif
        end
    end

    assign o_ack      = r_ack_q;
    assign o_done     = r_done_q;
    assign o_walk_req = r_walk_req_q;
    assign o_grant_id = r_grant_q;
    assign o_busy     = r_busy_q;
`ifdef WALKER_ARB_TIMEOUT_EN
    assign o_err      = r_err_q;
`else
    assign o_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_walker_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_walker_arbiter
// Purpose  : Directed scoreboard bench for walker_arbiter with a walker model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_walker_arbiter;

    localparam int NREQ = 4;
`ifdef WALKER_ARB_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 36_000_000;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] ack, done;
    logic            walk_req;
    logic            walk_busy = 1'b0;
    logic [1:0]      gid;
    logic            busy, err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    walker_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_req      (req),
        .o_ack      (ack),
        .o_done     (done),
        .o_walk_req (walk_req),
        .i_walk_busy(walk_busy),
        .o_grant_id (gid),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [NREQ-1:0] v);
        req = v;
        tick();
        req = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_walk_req"}, 32'(walk_req), 32'd0);
        check({tag, "_ack"},      32'(ack),      32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_gid"},      32'(gid),      32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        walk_busy = 1'b0;
        repeat (2) tick();
        check_quiet("reset");
        rst = 1'b0;
    endtask

    // Pop the expected grantee, then play the walker: busy after 'lat' cycles, walk of 'len' cycles.
    task automatic serve(input int lat, input int len, input logic [NREQ-1:0] mid);
        int exp_id;
        int waited;
        waited = 0;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
            exp_id = 0;
        end else begin
            exp_id = exp_q.pop_front();
        end
        while (walk_req !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("walk_req_rise", 32'(walk_req), 32'd1);
        check("grant_id",      32'(gid),      32'(exp_id));
        check("busy_issue",    32'(busy),     32'd1);
        repeat (lat - 1) tick();
        check("walk_req_hold", 32'(walk_req), 32'd1);
        walk_busy = 1'b1;
        tick();
        check("ack",           32'(ack),      32'd1 << exp_id);
        check("walk_req_drop", 32'(walk_req), 32'd0);
        check("done_with_ack", 32'(done),     32'd0);
        tick();
        check("ack_pulse",     32'(ack),      32'd0);
        if (mid != '0) pulse(mid);
        repeat (len) tick();
        walk_busy = 1'b0;
        tick();
        check("done",          32'(done),     32'd1 << exp_id);
        check("busy_idle",     32'(busy),     32'd0);
        tick();
        check("done_pulse",    32'(done),     32'd0);
    endtask

    initial begin
        int waited;

        // Single request from requester 2.
        do_reset();
        exp_q.push_back(2);
        pulse(4'b0100);
        serve(5, 20, '0);
        repeat (5) tick();
        check("single_no_regrant", 32'(walk_req), 32'd0);

        // Simultaneous 0 and 2, then 3 and 0 to expose rr pointer at 3.
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(2);
        pulse(4'b0101);
        serve(2, 4, '0);
        serve(3, 4, '0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        pulse(4'b1001);
        serve(2, 3, '0);
        serve(2, 3, '0);

        // Fairness with all requests held; released before the tenth walk.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(i % 4);
            if (i == 9) req = '0;
            serve(3, 6, '0);
        end
        // Bits re-queued while held drain in rr order from 2.
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(1);
        for (int i = 0; i < 4; i++) serve(2, 3, '0);
        repeat (6) tick();
        check("fair_drained", 32'(walk_req), 32'd0);

        // Re-request during own walk queues behind requester 3.
        do_reset();
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(1);
        pulse(4'b0010);
        serve(4, 8, 4'b1010);
        serve(2, 3, '0);
        serve(2, 3, '0);

        // Reset in WALK: outputs clear, pending cleared, no done for the orphan walk.
        do_reset();
        pulse(4'b0101);
        waited = 0;
        while (walk_req !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("rst_walk_grant", 32'(gid), 32'd0);
        walk_busy = 1'b1;
        tick();
        check("rst_walk_ack", 32'(ack), 32'd1);
        pulse(4'b0010);
        rst = 1'b1;
        tick();
        check_quiet("midwalk_reset");
        rst = 1'b0;
        repeat (3) tick();
        check("rst_no_req_while_busy", 32'(walk_req), 32'd0);
        walk_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_no_done",   32'(done),     32'd0);
            check("rst_no_regrant", 32'(walk_req), 32'd0);
        end

`ifdef WALKER_ARB_TIMEOUT_EN
        // ISSUE abort after TMO cycles with the walker never going busy.
        do_reset();
        pulse(4'b0011);
        waited = 0;
        while (walk_req !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("tmo_grant", 32'(gid), 32'd0);
        waited = 0;
        while (walk_req === 1'b1 && waited < 2 * TMO) begin
            check("tmo_no_ack", 32'(ack), 32'd0);
            waited++;
            tick();
        end
        check("tmo_issue_len", 32'(waited), 32'(TMO));
        check("tmo_err",       32'(err),    32'd1);
        check("tmo_done",      32'(done),   32'd0);
        tick();
        check("tmo_err_pulse", 32'(err),    32'd0);
        exp_q.push_back(1);
        serve(3, 5, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
